// File: rtl/load_store_port.sv
// load_store_port: execute-stage initiator onto the single-port word memory.
// Big-endian byte/half/word accesses; word-straddling ones take two cycles.
module load_store_port #(
  parameter  int MEMORY_DEPTH = 32768,
  localparam int AW = $clog2(MEMORY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_sign_extend,
  input  logic [31:0]   req_address,
  input  logic [31:0]   req_store_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_load_data,
  output logic          rsp_error,
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_wen,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t state, state_next;

  logic          accept;
  logic          bad;
  logic          split;
  logic [2:0]    nb;
  logic [1:0]    off;
  logic [3:0]    sh;
  logic [7:0]    bmask;
  logic [7:0]    lane_mask;
  logic [31:0]   sdata_m;
  logic [63:0]   wdata64;
  logic [AW-1:0] word;
  logic [AW-1:0] word_next;

  logic          store_q;
  logic          sign_q;
  logic          split_q;
  logic [1:0]    size_q;
  logic [3:0]    sh_q;
  logic [3:0]    wen0_q;
  logic [3:0]    wen1_q;
  logic [31:0]   wd1_q;
  logic [AW-1:0] word1_q;
  logic [31:0]   rd0_q;

  logic [63:0]   win;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  assign accept = req_valid && req_ready;

  // Vectors are numerically descending: lane/bit 0 here is the LSB end.
  // An 8-byte window (word 0 then word 1) holds the access at offset off.
  always_comb begin
    nb      = 3'd4;
    bmask   = 8'h0f;
    sdata_m = req_store_data;
    unique case (req_size)
      2'b00: begin
        nb      = 3'd1;
        bmask   = 8'h01;
        sdata_m = {24'h0, req_store_data[7:0]};
      end
      2'b01: begin
        nb      = 3'd2;
        bmask   = 8'h03;
        sdata_m = {16'h0, req_store_data[15:0]};
      end
      default: ;
    endcase
    off       = req_address[1:0];
    sh        = 4'd8 - {2'b00, off} - {1'b0, nb};
    lane_mask = bmask << sh;
    wdata64   = {32'h0, sdata_m} << {sh, 3'b000};
    split     = ({1'b0, off} + nb) > 3'd4;
    bad       = (req_size == 2'b11) ||
                ((req_address >> (AW + 2)) != 32'h0);
    word      = req_address[AW+1:2];
    word_next = (word == AW'(MEMORY_DEPTH - 1)) ?
                '0 : word + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:
        if (accept) state_next = bad ? S_RESPOND : S_ISSUE0;
      S_ISSUE0:
        state_next = split_q ? S_ISSUE1 : S_WAIT;
      S_ISSUE1:
        state_next = S_WAIT;
      S_WAIT:
        state_next = S_RESPOND;
      S_RESPOND:
        if (rsp_ready) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_wen   = 4'b0000;
    unique case (state)
      S_IDLE:    req_ready = rst_n;
      S_ISSUE0:  mem_wen   = wen0_q;
      S_ISSUE1:  mem_wen   = wen1_q;
      S_RESPOND: rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    win = split_q ? {rd0_q, mem_read_data}
                  : {mem_read_data, 32'h0};
    shifted   = 32'(win >> {sh_q, 3'b000});
    load_data = shifted;
    unique case (size_q)
      2'b00: load_data =
        {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01: load_data =
        {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q        <= 1'b0;
      sign_q         <= 1'b0;
      split_q        <= 1'b0;
      size_q         <= 2'b00;
      sh_q           <= 4'h0;
      wen0_q         <= 4'h0;
      wen1_q         <= 4'h0;
      wd1_q          <= 32'h0;
      word1_q        <= '0;
      rd0_q          <= 32'h0;
      rsp_load_data  <= 32'h0;
      rsp_error      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 32'h0;
    end else begin
      if (accept) begin
        store_q       <= req_store;
        sign_q        <= req_sign_extend;
        split_q       <= split;
        size_q        <= req_size;
        sh_q          <= sh;
        wen0_q        <= req_store ? lane_mask[7:4] : 4'h0;
        wen1_q        <= req_store ? lane_mask[3:0] : 4'h0;
        wd1_q         <= wdata64[31:0];
        word1_q       <= word_next;
        rsp_error     <= bad;
        rsp_load_data <= 32'h0;
        if (!bad) begin
          mem_address    <= word;
          mem_write_data <= wdata64[63:32];
        end
      end
      if (state == S_ISSUE0 && split_q) begin
        mem_address    <= word1_q;
        mem_write_data <= wd1_q;
      end
      if (state == S_ISSUE1)
        rd0_q <= mem_read_data;
      if (state == S_WAIT && !store_q)
        rsp_load_data <= load_data;
    end
  end

endmodule

// File: doc/load_store_port.md
# load_store_port

Initiator side of the single-port word memory: accepts byte/halfword/word load and store requests from the execute stage over a valid/ready handshake and drives the memory's word address, 4-bit byte write enable and write data. It captures the memory's one-cycle registered read data and returns aligned, optionally sign-extended load results. Byte addressing is big-endian, and accesses that straddle a word boundary are split into two memory cycles.

## Interface
- MEMORY_DEPTH, 32768, memory size in 32-bit words; AW = $clog2(MEMORY_DEPTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_sign_extend  in  1  loads only: sign-extend the result, otherwise zero-extend.
- req_address  in  32  byte address, [0:31], bit 31 is the LSB.
- req_store_data  in  32  store data, right-aligned (byte store uses [24:31]).
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts the response.
- rsp_load_data  out  32  right-aligned load result; 0 for stores and errors.
- rsp_error  out  1  request rejected: reserved size or out-of-range address.
- mem_address  out  AW  word index driven to the memory.
- mem_wen  out  4  byte lane enables; wen[k] covers bits [8k:8k+7].
- mem_write_data  out  32  write data with bytes placed in their lanes.
- mem_read_data  in  32  memory read data, valid the cycle after its address was driven.

## Operation
- States: IDLE, ISSUE0, ISSUE1, WAIT, RESPOND.
- Accept on req_valid && req_ready. All request fields are registered; the inputs are don't-care afterwards.
- Terms: n = 1/2/4 bytes; o = req_address[30:31]; word index w = req_address[30-AW:29].
- Error: size = 11, or any address bit [0:29-AW] set. The block goes IDLE -> RESPOND with rsp_error=1 and issues no memory cycle.
- split = (o + n > 4). Word 0 holds bytes o..min(o+n,4)-1. Word 1 is at (w+1) mod MEMORY_DEPTH and holds lanes 0..o+n-5.
- Big-endian placement: the most significant data byte goes to the lowest address. A store sets wen only for the lanes it covers. A load drives mem_wen=0.
- ISSUE0 drives word 0. Next state is ISSUE1 if split, otherwise WAIT.
- ISSUE1 drives word 1 and captures mem_read_data for word 0. Next state is WAIT.
- WAIT captures the read data of the last issued word. Next state is RESPOND.
- RESPOND asserts rsp_valid. Load data is assembled from the covered bytes and right-aligned. It is extended from bit 32-8n when sign-extending, otherwise zero-filled. Return to IDLE on rsp_ready.
- Outside ISSUE0/ISSUE1: mem_wen=0. mem_address and mem_write_data keep their last values.

## Timing
- Request accepted in cycle T:
  - unsplit: memory access in T+1, rsp_valid from T+3
  - split: memory accesses in T+1 and T+2, rsp_valid from T+4
  - error: rsp_valid from T+1
- At most one request is in flight. req_ready stays low from T+1 until the cycle after the response is accepted.
- Response fields are stable while rsp_valid=1 && rsp_ready=0.
- Reset values: req_ready=0 while rst_n=0 and 1 from the first cycle in IDLE; rsp_valid=0; rsp_error=0; rsp_load_data=0; mem_address=0; mem_wen=0; mem_write_data=0.
- Reset asserted mid-operation: mem_wen drops to 0 immediately (asynchronous reset) and the request is discarded. A write already clocked into memory is not undone; a split store may therefore be left half written.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x100. Expect one cycle with mem_address=0x40, wen=1111. Load of 0x100 returns 0xDEADBEEF at T+3.
- Byte lanes: store byte 0x80 to 0x103. Expect wen=0001 and data in [24:31]. Signed byte load from 0x103 returns 0xFFFFFF80; unsigned returns 0x00000080.
- Split halfword: store 0xA1B2 at 0x107. Expect wen=0001 on word 0x41, then wen=1000 on word 0x42. Load returns 0x0000A1B2 at T+4.
- Wrap-around: word store at byte 4*MEMORY_DEPTH-2 writes lanes 0011 of the last word, then lanes 1100 of word 0.
- Errors: size=11, or address 4*MEMORY_DEPTH, gives rsp_error=1 at T+1, mem_wen never set, rsp_load_data=0.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles and check the response stays stable and req_ready=0. Assert rst_n low during ISSUE1 of a split store and check wen=0 at once, rsp_valid=0, and the next request is accepted normally.
